// File: rtl/echo_request_input.sv
// Request-side portal for Echo: filters say writes into a small FIFO and drives the say method.
// Optional ECHO_REQ_BYPASS_EN forwards a say write straight to the output when the FIFO is empty.
module echo_request_input #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [15:0] SAY_METHOD = 16'd0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     EN_portal_enq,
    input  logic [15:0]              portal_enq_methodNumber,
    input  logic [31:0]              portal_enq_v,
    output logic                     RDY_portal_enq,
    output logic [31:0]              request_say_v,
    output logic                     EN_request_say,
    input  logic                     RDY_request_say,
    output logic [15:0]              err_count,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          accept;
    logic          is_say;
    logic          non_empty;
    logic          bypass;
    logic          push;
    logic          pop;

    // Ready is held low while reset is asserted, otherwise follows registered occupancy only.
    assign RDY_portal_enq = !RST && (fifo_count < FULL_COUNT);
    assign accept         = EN_portal_enq && RDY_portal_enq;
    assign is_say         = (portal_enq_methodNumber == SAY_METHOD);
    assign non_empty      = (fifo_count != '0);

`ifdef ECHO_REQ_BYPASS_EN
    assign bypass = accept && is_say && !non_empty && RDY_request_say;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && is_say && !bypass;
    assign pop  = non_empty && RDY_request_say;

    always_comb begin
        EN_request_say = pop || bypass;
        request_say_v  = '0;
        if (non_empty)
            request_say_v = mem[rd_ptr];
        else if (bypass)
            request_say_v = portal_enq_v;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_count <= '0;
        else if (accept && !is_say && (err_count != '1))
            err_count <= err_count + 1'b1;
    end

    // Storage is never reset; the output mux above masks it while empty.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= portal_enq_v;
    end

endmodule

// File: tb/tb_echo_request_input.sv
// Self-checking bench for echo_request_input: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_echo_request_input;

    localparam int DEPTH = 4;
`ifdef ECHO_REQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN_portal_enq = 1'b0;
    logic [15:0] portal_enq_methodNumber = '0;
    logic [31:0] portal_enq_v = '0;
    logic        RDY_portal_enq;
    logic [31:0] request_say_v;
    logic        EN_request_say;
    logic        RDY_request_say = 1'b0;
    logic [15:0] err_count;
    logic [2:0]  fifo_count;

    always #5 CLK = ~CLK;

    echo_request_input #(.DEPTH(DEPTH), .SAY_METHOD(16'd0)) dut (
        .CLK(CLK),
        .RST(RST),
        .EN_portal_enq(EN_portal_enq),
        .portal_enq_methodNumber(portal_enq_methodNumber),
        .portal_enq_v(portal_enq_v),
        .RDY_portal_enq(RDY_portal_enq),
        .request_say_v(request_say_v),
        .EN_request_say(EN_request_say),
        .RDY_request_say(RDY_request_say),
        .err_count(err_count),
        .fifo_count(fifo_count)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] q[$];
    int unsigned err_m = 0;

    typedef struct {
        logic        en;
        logic [15:0] m;
        logic [31:0] v;
        logic        rdy;
        logic        exp_en;
        logic [31:0] exp_v;
        int          exp_count;
        int          exp_err;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [15:0] m, input logic [31:0] v, input logic rdy);
        EN_portal_enq = en;
        portal_enq_methodNumber = m;
        portal_enq_v = v;
        RDY_request_say = rdy;
    endtask

    // One cycle: drive after the falling edge, compare before the rising edge, then advance the model.
    task automatic step(input logic en, input logic [15:0] m, input logic [31:0] v, input logic rdy);
        logic acc, say, byp, exp_en;
        logic [31:0] exp_v;
        @(negedge CLK);
        drive(en, m, v, rdy);
        #1;
        acc    = en && (q.size() < DEPTH);
        say    = (m == 16'd0);
        byp    = BYP && acc && say && (q.size() == 0) && rdy;
        exp_en = ((q.size() > 0) && rdy) || byp;
        exp_v  = (q.size() > 0) ? q[0] : (byp ? v : 32'd0);
        check("rdy_enq", {31'd0, RDY_portal_enq}, {31'd0, q.size() < DEPTH});
        check("en_say", {31'd0, EN_request_say}, {31'd0, exp_en});
        check("say_v", request_say_v, exp_v);
        check("fifo_count", {29'd0, fifo_count}, q.size());
        check("err_count", {16'd0, err_count}, err_m);
        if ((q.size() > 0) && rdy)
            void'(q.pop_front());
        if (acc && say && !byp)
            q.push_back(v);
        if (acc && !say && err_m < 65535)
            err_m++;
    endtask

    // Reset asserted between edges; outputs must clear before any clock edge.
    task automatic pulse_reset();
        @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("rst_rdy_enq", {31'd0, RDY_portal_enq}, 32'd0);
        check("rst_en_say", {31'd0, EN_request_say}, 32'd0);
        check("rst_say_v", request_say_v, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_err", {16'd0, err_count}, 32'd0);
        q.delete();
        err_m = 0;
        @(negedge CLK);
        drive(1'b0, 16'd0, 32'd0, 1'b0);
        RST = 1'b0;
        #1;
        check("post_rst_rdy_enq", {31'd0, RDY_portal_enq}, 32'd1);
    endtask

    initial begin
        tbl[0] = '{1'b1, 16'd3, 32'hAAAA0001, 1'b0, 1'b0, 32'd0,        0, 0};
        tbl[1] = '{1'b1, 16'd0, 32'hBBBB0002, 1'b0, 1'b0, 32'd0,        0, 1};
        tbl[2] = '{1'b1, 16'd7, 32'hCCCC0003, 1'b0, 1'b0, 32'hBBBB0002, 1, 1};
        tbl[3] = '{1'b0, 16'd0, 32'd0,        1'b1, 1'b1, 32'hBBBB0002, 1, 2};
        tbl[4] = '{1'b0, 16'd0, 32'd0,        1'b1, 1'b0, 32'd0,        0, 2};

        // Power-on reset state
        @(negedge CLK);
        #1;
        check("por_rdy_enq", {31'd0, RDY_portal_enq}, 32'd0);
        check("por_en_say", {31'd0, EN_request_say}, 32'd0);
        check("por_say_v", request_say_v, 32'd0);
        check("por_count", {29'd0, fifo_count}, 32'd0);
        check("por_err", {16'd0, err_count}, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("por_release_rdy_enq", {31'd0, RDY_portal_enq}, 32'd1);

        // Method filtering table: only the say word comes out, two errors counted
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            drive(tbl[i].en, tbl[i].m, tbl[i].v, tbl[i].rdy);
            #1;
            check($sformatf("tbl%0d_en", i), {31'd0, EN_request_say}, {31'd0, tbl[i].exp_en});
            check($sformatf("tbl%0d_v", i), request_say_v, tbl[i].exp_v);
            check($sformatf("tbl%0d_count", i), {29'd0, fifo_count}, tbl[i].exp_count);
            check($sformatf("tbl%0d_err", i), {16'd0, err_count}, tbl[i].exp_err);
        end

        // Single word latency
        pulse_reset();
        step(1'b1, 16'd0, 32'h12345678, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 32'd0, 1'b1);

        // Fill past DEPTH while stalled, then drain in order
        pulse_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 16'd0, i, 1'b0);
        check("full_count", {29'd0, fifo_count}, 32'd4);
        check("full_rdy_enq", {31'd0, RDY_portal_enq}, 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 32'd0, 1'b1);

        // Mid-operation reset discards buffered words
        for (int i = 0; i < 3; i++) step(1'b1, 16'd0, 32'hD000_0000 + i, 1'b0);
        pulse_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 16'd0, 32'd0, 1'b1);

        // Full-rate streaming with one word preloaded; pointers wrap several times
        step(1'b1, 16'd0, 32'h0000_0100, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 16'd0, 32'h0000_0200 + i, 1'b1);
        check("stream_count", {29'd0, fifo_count}, 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 16'd0, 32'd0, 1'b1);

        // Randomized traffic, including long stalls
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 9)) : 16'd0,
                 $urandom,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 16'd0, 32'd0, 1'b1);

        // Error counter saturation
        pulse_reset();
        @(negedge CLK);
        drive(1'b1, 16'd5, 32'd0, 1'b0);
        repeat (65534) @(posedge CLK);
        #1;
        check("err_near_sat", {16'd0, err_count}, 32'h0000FFFE);
        @(posedge CLK);
        err_m = 65535;
        step(1'b1, 16'd5, 32'd0, 1'b0);
        step(1'b0, 16'd0, 32'd0, 1'b0);
        check("err_sat", {16'd0, err_count}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
